// File: rtl/multiport_data_memory.sv
// Shared word array serving NUM_PORTS core ports: registered reads, lowest-port-wins
// write arbitration, and a post-reset sequencer that fills the array with a zero/LFSR image.
module multiport_data_memory #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 8,
    parameter int MEM_AW    = 8,
    parameter int SHARED    = 0,
    parameter int INIT_MODE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        ready,
    input  logic [NUM_PORTS*MEM_AW-1:0] addr,
    input  logic [NUM_PORTS-1:0]        re,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS*DATA_W-1:0] rdata,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic [NUM_PORTS-1:0]        wr_conflict
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam int SLICE = DEPTH / NUM_PORTS;
    localparam logic [MEM_AW-1:0] CNT_LAST  = {MEM_AW{1'b1}};
    localparam logic [7:0]        LFSR_SEED = 8'hA5;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [MEM_AW-1:0] port_offset(input int p);
        if (SHARED != 0) begin
            return {MEM_AW{1'b0}};
        end else begin
            return MEM_AW'((p * SLICE) % DEPTH);
        end
    endfunction

    logic [DATA_W-1:0]           mem_q [DEPTH];
    state_e                      state_q, state_d;
    logic [MEM_AW-1:0]           cnt_q, cnt_d;
    logic [7:0]                  lfsr_q, lfsr_d;
    logic                        ready_q, ready_d;
    logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]        rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0]        conflict_q, conflict_d;

    logic                        run_s;
    logic [NUM_PORTS-1:0]        re_s, we_s, lost_s, wr_win_s;
    logic [MEM_AW-1:0]           phys_s [NUM_PORTS];
    logic [DATA_W-1:0]           init_word_s;

    assign run_s       = (state_q == ST_RUN);
    assign re_s        = re & {NUM_PORTS{run_s}};
    assign we_s        = we & {NUM_PORTS{run_s}};
    assign init_word_s = (INIT_MODE != 0) ? DATA_W'(lfsr_q) : {DATA_W{1'b0}};

    // Init sequencer: one word per edge, hands over to RUN after the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            ST_INIT: begin
                cnt_d  = cnt_q + MEM_AW'(1);
                lfsr_d = lfsr_step(lfsr_q);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Address translation and write arbitration: a lower port on the same word wins
    always_comb begin
        lost_s     = {NUM_PORTS{1'b0}};
        wr_win_s   = {NUM_PORTS{1'b0}};
        conflict_d = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            phys_s[p] = addr[p*MEM_AW +: MEM_AW] + port_offset(p);
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if ((q < p) && we_s[q] && (phys_s[q] == phys_s[p])) begin
                    lost_s[p] = 1'b1;
                end else begin
                    lost_s[p] = lost_s[p];
                end
            end
            wr_win_s[p]   = we_s[p] & ~lost_s[p];
            conflict_d[p] = we_s[p] & lost_s[p];
        end
    end

    // Read path: array is sampled before this edge's writes land, giving read-first data
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re_s;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (re_s[p]) begin
                rdata_d[p*DATA_W +: DATA_W] = mem_q[phys_s[p]];
            end else begin
                rdata_d[p*DATA_W +: DATA_W] = rdata_q[p*DATA_W +: DATA_W];
            end
        end
    end

    // Array write port; contents deliberately survive reset and are rewritten by init
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= init_word_s;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_win_s[p]) begin
                    mem_q[phys_s[p]] <= wdata[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= {MEM_AW{1'b0}};
            lfsr_q     <= LFSR_SEED;
            ready_q    <= 1'b0;
            rdata_q    <= {(NUM_PORTS*DATA_W){1'b0}};
            rvalid_q   <= {NUM_PORTS{1'b0}};
            conflict_q <= {NUM_PORTS{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            conflict_q <= conflict_d;
        end
    end

    assign ready       = ready_q;
    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_multiport_data_memory.sv
// Scoreboard bench: a partitioned/LFSR instance and a shared/zero instance share one
// randomized stimulus stream and are checked against an array-based reference model.
module tb_multiport_data_memory;
    localparam int NP    = 2;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int SLICE = DEPTH / NP;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  rvalid;
        logic [1:0]  conf;
        logic [15:0] rdata;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr  = 16'h0000;
    logic [1:0]  re    = 2'b00;
    logic [1:0]  we    = 2'b00;
    logic [15:0] wdata = 16'h0000;

    logic        ready0, ready1;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  rvalid0, rvalid1, conf0, conf1;

    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb0 [$];
    exp_t        sb1 [$];
    logic [7:0]  mdl_mem [2][DEPTH];
    logic [15:0] mdl_rd  [2];
    int          SH [2] = '{0, 1};
    int          IM [2] = '{1, 0};

    multiport_data_memory #(.NUM_PORTS(NP), .DATA_W(DW), .MEM_AW(AW), .SHARED(0), .INIT_MODE(1)) u0 (
        .clk(clk), .reset(reset), .ready(ready0), .addr(addr), .re(re), .we(we),
        .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0), .wr_conflict(conf0));

    multiport_data_memory #(.NUM_PORTS(NP), .DATA_W(DW), .MEM_AW(AW), .SHARED(1), .INIT_MODE(0)) u1 (
        .clk(clk), .reset(reset), .ready(ready1), .addr(addr), .re(re), .we(we),
        .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .wr_conflict(conf1));

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, req, edge_cnt);
    endtask

    // Reference image: word i is the i-th LFSR state from 0xA5, or zero
    task automatic mdl_init(int k);
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[k][i] = (IM[k] != 0) ? l : 8'h00;
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        mdl_rd[k] = 16'h0000;
    endtask

    // One accepted request cycle: reads see old data, first port to claim a word keeps it
    task automatic mdl_step(int k, output exp_t e);
        int ph [NP];
        bit claimed [DEPTH];
        e.cyc    = edge_cnt + 1;
        e.rvalid = re;
        e.conf   = 2'b00;
        for (int p = 0; p < NP; p++)
            ph[p] = (int'(addr[p*AW +: AW]) + ((SH[k] != 0) ? 0 : p * SLICE)) % DEPTH;
        for (int p = 0; p < NP; p++)
            if (re[p]) mdl_rd[k][p*DW +: DW] = mdl_mem[k][ph[p]];
        e.rdata = mdl_rd[k];
        for (int i = 0; i < DEPTH; i++) claimed[i] = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (we[p]) begin
                if (claimed[ph[p]]) e.conf[p] = 1'b1;
                else begin
                    claimed[ph[p]] = 1'b1;
                    mdl_mem[k][ph[p]] = wdata[p*DW +: DW];
                end
            end
        end
    endtask

    task automatic issue(logic [15:0] a, logic [1:0] r, logic [1:0] w, logic [15:0] d);
        exp_t e;
        @(negedge clk);
        addr = a; re = r; we = w; wdata = d;
        mdl_step(0, e);
        if ((e.rvalid | e.conf) != 2'b00) sb0.push_back(e);
        mdl_step(1, e);
        if ((e.rvalid | e.conf) != 2'b00) sb1.push_back(e);
    endtask

    task automatic mon_one(int k, logic [1:0] rv, logic [1:0] cf, logic [15:0] rd);
        exp_t e;
        if ((rv | cf) != 2'b00) begin
            if (((k == 0) ? sb0.size() : sb1.size()) == 0) begin
                chk($sformatf("u%0d_unexpected_output", k), {28'h0, rv, cf}, 32'h0);
            end else begin
                if (k == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk($sformatf("u%0d_out_cycle", k), edge_cnt, e.cyc);
                chk($sformatf("u%0d_rvalid", k), {30'h0, rv}, {30'h0, e.rvalid});
                chk($sformatf("u%0d_wr_conflict", k), {30'h0, cf}, {30'h0, e.conf});
                chk($sformatf("u%0d_rdata", k), {16'h0, rd}, {16'h0, e.rdata});
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_one(0, rvalid0, conf0, rdata0);
            mon_one(1, rvalid1, conf1, rdata1);
        end
    end

    // Release reset and walk the DEPTH-edge fill, poking requests that must be ignored
    task automatic run_init();
        mdl_init(0);
        mdl_init(1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 10) begin
                addr = 16'h0503; re = 2'b11; we = 2'b11; wdata = 16'hEEDD;
            end else begin
                addr = 16'h0000; re = 2'b00; we = 2'b00; wdata = 16'h0000;
            end
            @(posedge clk);
            #1;
            chk("u0_ready_init", {31'h0, ready0}, 32'(i == DEPTH));
            chk("u1_ready_init", {31'h0, ready1}, 32'(i == DEPTH));
            if (i == 11) begin
                chk("u0_rvalid_in_init", {30'h0, rvalid0}, 32'h0);
                chk("u1_rvalid_in_init", {30'h0, rvalid1}, 32'h0);
                chk("u0_conflict_in_init", {30'h0, conf0}, 32'h0);
            end
        end
    endtask

    function automatic logic [7:0] rnd_addr();
        logic [7:0] a;
        a = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a = a | 8'h80;
        if ($urandom_range(0, 3) == 0) a = 8'($urandom);
        return a;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("u0_reset_ready", {31'h0, ready0}, 32'h0);
        chk("u1_reset_ready", {31'h0, ready1}, 32'h0);
        chk("u0_reset_rdata", {16'h0, rdata0}, 32'h0);
        chk("u0_reset_rvalid", {30'h0, rvalid0}, 32'h0);
        chk("u1_reset_conflict", {30'h0, conf1}, 32'h0);

        run_init();

        issue(16'h8000, 2'b11, 2'b00, 16'h0000);  // p0 @0, p1 @128 (wraps to phys 0 when partitioned)
        issue(16'h0001, 2'b01, 2'b00, 16'h0000);
        issue(16'h0503, 2'b11, 2'b00, 16'h0000);  // words poked during init must be intact
        issue(16'h0500, 2'b00, 2'b10, 16'h3C00);
        issue(16'h0085, 2'b01, 2'b00, 16'h0000);
        issue(16'h1010, 2'b00, 2'b11, 16'h2211);
        issue(16'h1090, 2'b00, 2'b11, 16'h4433);
        issue(16'h1010, 2'b11, 2'b00, 16'h0000);
        issue(16'h1090, 2'b11, 2'b00, 16'h0000);
        issue(16'h8303, 2'b10, 2'b01, 16'h0077);  // read-during-write on the same physical word
        issue(16'h0303, 2'b10, 2'b01, 16'h0088);
        issue(16'h8303, 2'b11, 2'b00, 16'h0000);
        issue(16'h0707, 2'b11, 2'b11, 16'h5566);
        issue(16'h0707, 2'b11, 2'b00, 16'h0000);

        for (int n = 0; n < 400; n++)
            issue({rnd_addr(), rnd_addr()}, 2'($urandom), 2'($urandom), 16'($urandom));
        issue(16'h0000, 2'b00, 2'b00, 16'h0000);
        issue(16'h0585, 2'b11, 2'b00, 16'h0000);

        @(posedge clk);
        #2;
        reset = 1'b0;
        addr = 16'h0000; re = 2'b00; we = 2'b00; wdata = 16'h0000;
        #1;
        chk("u0_midrun_ready", {31'h0, ready0}, 32'h0);
        chk("u0_midrun_rvalid", {30'h0, rvalid0}, 32'h0);
        chk("u0_midrun_rdata", {16'h0, rdata0}, 32'h0);
        chk("u1_midrun_ready", {31'h0, ready1}, 32'h0);
        chk("u1_midrun_rdata", {16'h0, rdata1}, 32'h0);
        repeat (3) @(posedge clk);

        run_init();
        for (int i = 0; i < DEPTH; i++)
            issue({8'(i), 8'(i)}, 2'b11, 2'b00, 16'h0000);
        issue(16'h0000, 2'b00, 2'b00, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("u0_scoreboard_drained", sb0.size(), 32'h0);
        chk("u1_scoreboard_drained", sb1.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
